fifo_wr_arbiter: RTL and testbench

//  Shares the single write port of the async FIFO write domain among N_REQ requesters.

---
 rtl/fifo_wr_arbiter_pkg.sv | 19 +
 rtl/fifo_wr_arbiter_rr_pick.sv | 58 +++++
 rtl/fifo_wr_arbiter.sv | 144 ++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 473 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_pkg
//   Shared definitions for the FIFO write-port arbiter:
//     - default widths for the write domain (requester count, data width,
//       burst cap)
//     - arbiter FSM state encoding
// ---------------------------------------------------------------------------
package fifo_wr_arbiter_pkg;

    localparam int DEF_N_REQ     = 4;
    localparam int DEF_DW        = 8;
    localparam int DEF_MAX_BURST = 4;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } arb_state_t;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter_rr_pick
//   Combinational rotating-priority picker. Finds the first asserted request
//   starting at rr_ptr and wrapping modulo N_REQ.
//
//   Ports
//     req     in   N_REQ   request vector
//     rr_ptr  in   IDX_W   index with highest priority this round
//     pick    out  N_REQ   one-hot winner (zero when nothing requests)
//     idx     out  IDX_W   winner index (zero when nothing requests)
//     any     out  1       at least one request present
// ---------------------------------------------------------------------------
module fifo_wr_arbiter_rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = $clog2(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [N_REQ-1:0] pick,
    output logic [IDX_W-1:0] idx,
    output logic             any
);

    logic [2*N_REQ-1:0] dbl;
    logic [N_REQ-1:0]   rot;
    logic [N_REQ-1:0]   rot_pick;
    logic [IDX_W-1:0]   rot_idx;
    logic [IDX_W:0]     sum;

    always_comb begin
        // Rotate right by rr_ptr so the highest-priority requester sits at bit 0.
        dbl = {req, req};
        rot = N_REQ'(dbl >> rr_ptr);

        // Priority encode: scanning downwards leaves the lowest set bit.
        rot_idx = '0;
        any     = 1'b0;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (rot[i]) begin
                rot_idx = IDX_W'(i);
                any     = 1'b1;
            end
        end

        // Undo the rotation: index wraps modulo N_REQ (N_REQ need not be 2^n).
        sum = {1'b0, rot_idx} + {1'b0, rr_ptr};
        if (sum >= (IDX_W+1)'(N_REQ)) begin
            sum = sum - (IDX_W+1)'(N_REQ);
        end
        idx = sum[IDX_W-1:0];

        // Rotate the one-hot winner left by the same amount.
        rot_pick = any ? (N_REQ'(1) << rot_idx) : '0;
        dbl      = {rot_pick, rot_pick} << rr_ptr;
        pick     = dbl[2*N_REQ-1:N_REQ];
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_wr_arbiter
//   Shares the single write port of the async FIFO write domain among N_REQ
//   requesters. Round-robin priority, burst grants of up to MAX_BURST words or
//   until the requester's last word. Stalls on the registered full flag.
//
//   Handshake: requester k offers a word by holding i_req[k] with i_data[k];
//   the word is taken in the cycle where i_req[k] & o_ready[k]. o_ready is only
//   ever set for the granted requester while i_full is low, and o_winc mirrors
//   it. Dropping i_req while granted abandons the grant without a transfer.
//
//   Ports
//     i_wclk    in   1          write-domain clock
//     i_wrst_n  in   1          async active-low reset
//     i_req     in   N_REQ      per-requester word valid
//     i_last    in   N_REQ      per-requester last word (qualified by i_req)
//     i_data    in   N_REQ*DW   requester k at [k*DW +: DW]
//     i_full    in   1          registered full flag
//     o_ready   out  N_REQ      one-hot word accepted this cycle
//     o_winc    out  1          FIFO write increment
//     o_wdata   out  DW         granted requester's word, zero when idle
//     o_grant   out  N_REQ      registered one-hot grant, zero when idle
//     o_busy    out  1          FSM in GRANT state (state visibility)
// ---------------------------------------------------------------------------
module fifo_wr_arbiter
    import fifo_wr_arbiter_pkg::*;
#(
    parameter int N_REQ     = DEF_N_REQ,
    parameter int DW        = DEF_DW,
    parameter int MAX_BURST = DEF_MAX_BURST,
    parameter int IDX_W     = $clog2(N_REQ),
    parameter int CNT_W     = $clog2(MAX_BURST + 1)
) (
    input  logic                i_wclk,
    input  logic                i_wrst_n,
    input  logic [N_REQ-1:0]    i_req,
    input  logic [N_REQ-1:0]    i_last,
    input  logic [N_REQ*DW-1:0] i_data,
    input  logic                i_full,
    output logic [N_REQ-1:0]    o_ready,
    output logic                o_winc,
    output logic [DW-1:0]       o_wdata,
    output logic [N_REQ-1:0]    o_grant,
    output logic                o_busy
);

    arb_state_t       state_q, state_d;
    logic [IDX_W-1:0] g_q, g_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] rr_q, rr_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [N_REQ-1:0] pick_oh;
    logic [IDX_W-1:0] pick_idx;
    logic             pick_any;

    logic             granted;
    logic             cur_req;
    logic             cur_last;
    logic [DW-1:0]    cur_data;
    logic             xfer;
    logic             at_cap;
    logic             burst_end;
    logic [IDX_W-1:0] g_next;

    fifo_wr_arbiter_rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_rr_pick (
        .req    (i_req),
        .rr_ptr (rr_q),
        .pick   (pick_oh),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    assign granted  = (state_q == ST_GRANT);
    assign cur_req  = i_req[g_q];
    assign cur_last = i_last[g_q];
    assign cur_data = i_data[g_q*DW +: DW];

    // Full is honoured here even though the pointer handler also gates winc.
    assign xfer      = granted & cur_req & ~i_full;
    assign at_cap    = (cnt_q == CNT_W'(MAX_BURST - 1));
    assign burst_end = granted & ((xfer & (cur_last | at_cap)) | ~cur_req);
    assign g_next    = (g_q == IDX_W'(N_REQ - 1)) ? '0 : g_q + 1'b1;

    assign o_winc  = xfer;
    assign o_ready = xfer ? grant_q : '0;
    assign o_wdata = granted ? cur_data : '0;
    assign o_grant = grant_q;
    assign o_busy  = granted;

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        grant_d = grant_q;
        rr_d    = rr_q;
        cnt_d   = cnt_q;
        case (state_q)
            ST_IDLE: begin
                if (pick_any) begin
                    state_d = ST_GRANT;
                    g_d     = pick_idx;
                    grant_d = pick_oh;
                    cnt_d   = '0;
                end
            end
            ST_GRANT: begin
                if (xfer) begin
                    cnt_d = cnt_q + 1'b1;
                end
                // Every burst returns to IDLE, giving the one-cycle bubble
                // in which the next winner is chosen.
                if (burst_end) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                    rr_d    = g_next;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge i_wclk or negedge i_wrst_n) begin
        if (!i_wrst_n) begin
            state_q <= ST_IDLE;
            g_q     <= '0;
            grant_q <= '0;
            rr_q    <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            grant_q <= grant_d;
            rr_q    <= rr_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_wr_arbiter
//   Directed scenarios plus a long randomized run against a behavioural
//   model of the arbitration rules and a write-stream scoreboard.
// ---------------------------------------------------------------------------
module tb_fifo_wr_arbiter;

  localparam int N_REQ     = 4;
  localparam int DW        = 8;
  localparam int MAX_BURST = 4;

  // ---------------- clock / reset ----------------
  logic i_wclk = 1'b0;
  logic i_wrst_n;
  always #5 i_wclk = ~i_wclk;

  logic [N_REQ-1:0]    req;
  logic [N_REQ-1:0]    last;
  logic [N_REQ*DW-1:0] data;
  logic                full;
  logic [N_REQ-1:0]    o_ready;
  logic                o_winc;
  logic [DW-1:0]       o_wdata;
  logic [N_REQ-1:0]    o_grant;
  logic                o_busy;

  fifo_wr_arbiter #(
    .N_REQ     (N_REQ),
    .DW        (DW),
    .MAX_BURST (MAX_BURST)
  ) dut (
    .i_wclk   (i_wclk),
    .i_wrst_n (i_wrst_n),
    .i_req    (req),
    .i_last   (last),
    .i_data   (data),
    .i_full   (full),
    .o_ready  (o_ready),
    .o_winc   (o_winc),
    .o_wdata  (o_wdata),
    .o_grant  (o_grant),
    .o_busy   (o_busy)
  );

  int checks   = 0;
  int failures = 0;
  int printed  = 0;

  // ---------------- reference model ----------------
  // owner = requester currently holding the port (-1 none), rr = where the
  // next search starts, words = words moved in the current burst.
  int               m_owner;
  int               m_rr;
  int               m_words;
  logic             e_busy;
  logic             e_winc;
  logic [N_REQ-1:0] e_grant;
  logic [N_REQ-1:0] e_ready;
  logic [DW-1:0]    e_wdata;

  logic [DW-1:0]    exp_q[$];

  function automatic void model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_words = 0;
  endfunction

  function automatic void model_eval();
    e_busy  = 1'b0;
    e_winc  = 1'b0;
    e_grant = '0;
    e_ready = '0;
    e_wdata = '0;
    if (m_owner >= 0) begin
      e_busy           = 1'b1;
      e_grant[m_owner] = 1'b1;
      e_wdata          = data[m_owner*DW +: DW];
      if (req[m_owner] && !full) begin
        e_winc = 1'b1;
        e_ready = e_grant;
      end
    end
  endfunction

  function automatic void model_step();
    bit found;
    bit moved;
    int k;
    found = 1'b0;
    if (m_owner < 0) begin
      for (int i = 0; i < N_REQ; i++) begin
        k = (m_rr + i) % N_REQ;
        if (!found && req[k]) begin
          found   = 1'b1;
          m_owner = k;
          m_words = 0;
        end
      end
    end else begin
      moved = req[m_owner] && !full;
      if ((moved && (last[m_owner] || (m_words + 1 == MAX_BURST))) || !req[m_owner]) begin
        m_rr    = (m_owner + 1) % N_REQ;
        m_owner = -1;
        m_words = 0;
      end else if (moved) begin
        m_words++;
      end
    end
  endfunction

  // ---------------- driver tasks ----------------
  task automatic settle();
    @(negedge i_wclk);
    model_eval();
  endtask

  task automatic advance();
    model_step();
    @(posedge i_wclk);
    #1;
  endtask

  task automatic do_reset();
    i_wrst_n = 1'b0;
    req  = '0;
    last = '0;
    full = 1'b0;
    data = '0;
    model_reset();
    @(posedge i_wclk);
    #1;
    @(posedge i_wclk);
    #1;
    i_wrst_n = 1'b1;
  endtask

  function automatic logic [17:0] pk(input logic busy, input logic [3:0] grant,
                                     input logic winc, input logic [3:0] ready,
                                     input logic [7:0] wdata);
    return {busy, grant, winc, ready, wdata};
  endfunction

  function automatic logic [17:0] obs();
    return {o_busy, o_grant, o_winc, o_ready, o_wdata};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    i_wrst_n = 1'b0;
    req  = 4'b1111;
    last = '0;
    full = 1'b0;
    data = 32'h44332211;
    model_reset();
    #2;
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL reset_async: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
    end
    @(posedge i_wclk);
    #1;
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL reset_held: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
    end
    i_wrst_n = 1'b1;
    settle();
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL reset_idle: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
    end
    advance();
    settle();
    checks++;
    if (obs() !== pk(1, 4'b0001, 1, 4'b0001, 8'h11)) begin
      failures++; $display("FAIL reset_first_grant: got %h want %h", obs(), pk(1, 4'b0001, 1, 4'b0001, 8'h11));
    end
    advance();
  endtask

  task automatic test_single_burst();
    do_reset();
    req = 4'b0001;
    data[7:0] = 8'hA0;
    settle();
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL single_latency: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
    end
    advance();
    for (int w = 0; w < 3; w++) begin
      data[7:0] = 8'hA0 + 8'(w);
      last[0]   = (w == 2);
      settle();
      checks++;
      if (obs() !== pk(1, 4'b0001, 1, 4'b0001, 8'hA0 + 8'(w))) begin
        failures++; $display("FAIL single_word%0d: got %h want %h", w, obs(), pk(1, 4'b0001, 1, 4'b0001, 8'hA0 + 8'(w)));
      end
      advance();
    end
    req  = '0;
    last = '0;
    settle();
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL single_idle_after: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
    end
    advance();
    // Pointer moved to 1: with 0 and 1 both requesting, 1 must win.
    req = 4'b0011;
    data[15:8] = 8'hB0;
    settle();
    advance();
    settle();
    checks++;
    if (obs() !== pk(1, 4'b0010, 1, 4'b0010, 8'hB0)) begin
      failures++; $display("FAIL single_rr_next: got %h want %h", obs(), pk(1, 4'b0010, 1, 4'b0010, 8'hB0));
    end
    advance();
    req = '0;
    settle();
    checks++;
    if (obs() !== pk(1, 4'b0010, 0, 4'b0000, 8'hB0)) begin
      failures++; $display("FAIL single_abandon: got %h want %h", obs(), pk(1, 4'b0010, 0, 4'b0000, 8'hB0));
    end
    advance();
  endtask

  task automatic test_round_robin();
    int writes[N_REQ];
    logic [N_REQ-1:0] oh;
    do_reset();
    for (int k = 0; k < N_REQ; k++) writes[k] = 0;
    req = 4'b1111;
    for (int b = 0; b < 5; b++) begin
      data = $urandom;
      settle();
      checks++;
      if (obs() !== pk(0, 0, 0, 0, 0)) begin
        failures++; $display("FAIL rr_bubble%0d: got %h want %h", b, obs(), pk(0, 0, 0, 0, 0));
      end
      advance();
      oh = '0;
      oh[b % N_REQ] = 1'b1;
      for (int w = 0; w < MAX_BURST; w++) begin
        data = $urandom;
        settle();
        for (int k = 0; k < N_REQ; k++) if (b < N_REQ && o_ready[k]) writes[k]++;
        checks++;
        if (obs() !== pk(1, oh, 1, oh, data[(b % N_REQ)*DW +: DW])) begin
          failures++; $display("FAIL rr_burst%0d_w%0d: got %h want %h", b, w, obs(), pk(1, oh, 1, oh, data[(b % N_REQ)*DW +: DW]));
        end
        advance();
      end
    end
    for (int k = 0; k < N_REQ; k++) begin
      checks++;
      if (writes[k] !== MAX_BURST) begin
        failures++; $display("FAIL rr_count%0d: got %0d want %0d", k, writes[k], MAX_BURST);
      end
    end
    req = '0;
    settle();
    advance();
  endtask

  task automatic test_full_stall();
    do_reset();
    req = 4'b0001;
    data[7:0] = 8'h50;
    settle();
    advance();
    for (int c = 0; c < 9; c++) begin
      data[7:0] = 8'h50 + 8'(c);
      full = (c >= 2 && c < 7);
      settle();
      checks++;
      if (obs() !== pk(1, 4'b0001, !full, full ? 4'b0000 : 4'b0001, 8'h50 + 8'(c))) begin
        failures++; $display("FAIL full_c%0d: got %h want %h", c, obs(), pk(1, 4'b0001, !full, full ? 4'b0000 : 4'b0001, 8'h50 + 8'(c)));
      end
      checks++;
      if (o_winc && full) begin
        failures++; $display("FAIL full_winc: got winc=1 want 0");
      end
      advance();
    end
    // Two words before and two after the stall: the cap ends the burst here.
    full = 1'b0;
    settle();
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL full_burst_end: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
    end
    advance();
    req = '0;
    settle();
    advance();
  endtask

  task automatic test_abandon();
    do_reset();
    req = 4'b0100;
    data = 32'h33221100;
    settle();
    advance();
    settle();
    checks++;
    if (obs() !== pk(1, 4'b0100, 1, 4'b0100, 8'h22)) begin
      failures++; $display("FAIL abandon_word: got %h want %h", obs(), pk(1, 4'b0100, 1, 4'b0100, 8'h22));
    end
    advance();
    req = '0;
    settle();
    checks++;
    if (obs() !== pk(1, 4'b0100, 0, 4'b0000, 8'h22)) begin
      failures++; $display("FAIL abandon_drop: got %h want %h", obs(), pk(1, 4'b0100, 0, 4'b0000, 8'h22));
    end
    advance();
    req = 4'b1111;
    settle();
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL abandon_idle: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
    end
    advance();
    settle();
    checks++;
    if (obs() !== pk(1, 4'b1000, 1, 4'b1000, 8'h33)) begin
      failures++; $display("FAIL abandon_next3: got %h want %h", obs(), pk(1, 4'b1000, 1, 4'b1000, 8'h33));
    end
    advance();
    req = '0;
    settle();
    advance();
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    data = 32'hD3D2D1D0;
    req  = 4'b0010;
    last = 4'b0010;
    settle();
    advance();
    settle();
    advance();
    req  = 4'b1111;
    last = '0;
    settle();
    advance();
    settle();
    checks++;
    if (obs() !== pk(1, 4'b0100, 1, 4'b0100, 8'hD2)) begin
      failures++; $display("FAIL rstmid_pre: got %h want %h", obs(), pk(1, 4'b0100, 1, 4'b0100, 8'hD2));
    end
    #2;
    i_wrst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs() !== pk(0, 0, 0, 0, 0)) begin
      failures++; $display("FAIL rstmid_clear: got %h want %h", obs(), pk(0, 0, 0, 0, 0));
    end
    @(posedge i_wclk);
    #1;
    i_wrst_n = 1'b1;
    settle();
    advance();
    settle();
    checks++;
    if (obs() !== pk(1, 4'b0001, 1, 4'b0001, 8'hD0)) begin
      failures++; $display("FAIL rstmid_restart0: got %h want %h", obs(), pk(1, 4'b0001, 1, 4'b0001, 8'hD0));
    end
    advance();
    req = '0;
    settle();
    advance();
  endtask

  task automatic test_random();
    logic [5:0]    seq[N_REQ];
    logic [5:0]    obs_next[N_REQ];
    logic [DW-1:0] head;
    int            owner;
    do_reset();
    exp_q.delete();
    for (int k = 0; k < N_REQ; k++) begin
      seq[k]      = '0;
      obs_next[k] = '0;
    end
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int k = 0; k < N_REQ; k++) begin
        req[k]  = ($urandom_range(0, 3) != 0);
        last[k] = ($urandom_range(0, 3) == 0);
        data[k*DW +: DW] = {2'(k), seq[k]};
      end
      full = ($urandom_range(0, 4) == 0);
      settle();
      checks++;
      if (obs() !== pk(e_busy, e_grant, e_winc, e_ready, e_wdata)) begin
        failures++;
        if (printed < 20) begin
          printed++; $display("FAIL rand_outputs cyc%0d: got %h want %h", cyc, obs(), pk(e_busy, e_grant, e_winc, e_ready, e_wdata));
        end
      end
      checks++;
      if (o_winc && full) begin
        failures++;
        if (printed < 20) begin
          printed++; $display("FAIL rand_winc_full cyc%0d: got winc=1 want 0", cyc);
        end
      end
      if (e_winc) exp_q.push_back(e_wdata);
      if (o_winc) begin
        checks++;
        if (exp_q.size() == 0) begin
          failures++;
          if (printed < 20) begin
            printed++; $display("FAIL rand_extra_write cyc%0d: got %h want none", cyc, o_wdata);
          end
        end else begin
          head = exp_q.pop_front();
          if (o_wdata !== head) begin
            failures++;
            if (printed < 20) begin
              printed++; $display("FAIL rand_stream cyc%0d: got %h want %h", cyc, o_wdata, head);
            end
          end
        end
        checks++;
        if (o_wdata[5:0] !== obs_next[o_wdata[7:6]]) begin
          failures++;
          if (printed < 20) begin
            printed++; $display("FAIL rand_order cyc%0d: got seq %0d want %0d", cyc, o_wdata[5:0], obs_next[o_wdata[7:6]]);
          end
        end
        obs_next[o_wdata[7:6]] = o_wdata[5:0] + 6'd1;
      end
      owner = m_owner;
      if (e_winc) seq[owner] = seq[owner] + 6'd1;
      advance();
    end
    checks++;
    if (exp_q.size() != 0) begin
      failures++; $display("FAIL rand_lost_words: got %0d pending want 0", exp_q.size());
    end
    req = '0;
    settle();
    advance();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_single_burst();
    test_round_robin();
    test_full_stall();
    test_abandon();
    test_reset_mid_burst();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL watchdog: got timeout want completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
